cam_sccb_master: RTL and testbench
==================================

CAM_SCCB_MASTER -- requirements
Module: cam_sccb_master

Interface
REQ-001 Parameter QTR_DIV, default 250, clk cycles per quarter SCL period (100 kHz SCL at 100 MHz clk); legal range is 2 or greater.
REQ-002 clk  input  1  single clock; all logic is on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 i2c_data  input  24  {slave_addr_w, reg_addr, reg_value}, sent MSB first.
REQ-005 enable  input  1  level request; a transfer starts when enable is sampled high in IDLE.
REQ-006 scl_o  output  1  SCCB clock, push-pull; no clock stretching is supported.
REQ-007 sda_oe  output  1  1 = pull SDA low; 0 = release SDA (pad is open-drain, pulled high).
REQ-008 sda_i  input  1  SDA pad level, already synchronised upstream.
REQ-009 busy  output  1  high in every state except IDLE and DONE.
REQ-010 done  output  1  transfer complete; stays high while in DONE.
REQ-011 ack_err  output  1  1 = at least one ACK slot sampled high (NACK); valid while done=1.

Function
REQ-012 The block SHALL contain a quarter-tick divider: a counter from 0 to QTR_DIV-1 that emits qtick on its terminal count; the counter is held at 0 in IDLE and DONE.
REQ-013 The FSM SHALL have the states IDLE, START, BIT, STOP and DONE.
REQ-014 IDLE: scl_o=1, sda_oe=0. When enable=1 the block latches i2c_data into a shift register, clears ack_err and moves to START on the same edge.
REQ-015 START (2 quarters): quarter A scl_o=1, sda_oe=1; quarter B scl_o=0, sda_oe=1; then go to BIT with slot=0.
REQ-016 BIT covers 27 slots (0..26). Slots 8, 17 and 26 are ACK slots; all other slots carry the next shift-register MSB.
REQ-017 Each slot is 4 quarters:
  - q0: scl_o=0, SDA is set up (data slot: sda_oe = ~bit; ACK slot: sda_oe=0).
  - q1: scl_o=1.
  - q2: scl_o=1; on an ACK slot, sda_i is sampled at the qtick ending q2 and OR-ed into ack_err.
  - q3: scl_o=0.
REQ-018 The shift register SHALL shift left by one at the end of each data slot; the slot counter is 5 bits and does not wrap past 26.
REQ-019 After slot 26 q3 the FSM SHALL go to STOP.
REQ-020 STOP (3 quarters): (scl_o=0, sda_oe=1), (scl_o=1, sda_oe=1), (scl_o=1, sda_oe=0); then go to DONE.
REQ-021 SDA SHALL change only while scl_o=0, except at the START and STOP edges.
REQ-022 Latency: with enable sampled high at edge N, done SHALL be 1 from edge N+1+113*QTR_DIV.
REQ-023 DONE: scl_o=1, sda_oe=0, done=1. The FSM returns to IDLE on the first edge where enable=0. If enable is already low on entry, done is high for exactly one cycle.
REQ-024 A NACK SHALL NOT abort the transfer; it always runs through STOP. Retry is the caller's decision.
REQ-025 Changes on i2c_data or enable during START, BIT or STOP SHALL NOT affect the transfer in progress.
REQ-026 Holding enable high in DONE SHALL NOT start a new transfer; a new transfer needs enable low, then high again.

Reset
REQ-027 While reset=0 at an edge, the outputs SHALL be scl_o=1, sda_oe=0, busy=0, done=0, ack_err=0, with FSM=IDLE and all counters and the shift register cleared.
REQ-028 Reset asserted mid-transfer SHALL abort on that edge; the incomplete bus frame is accepted and the next START re-synchronises the slave.

Verification (QTR_DIV=2)
REQ-029 enable pulse, i2c_data=0x421280, slave ACKs every slot -> SDA bit stream 0x42,0x12,0x80 with ACK slots released, ack_err=0, done rises at cycle 227.
REQ-030 Slave drives NACK only in slot 17 -> ack_err=1 at done, STOP sequence still completes, done rises at cycle 227.
REQ-031 enable held high through done for 10 cycles, then low, then high -> done stays 1 for those 10 cycles, IDLE follows the next cycle, then a second full transfer runs.
REQ-032 i2c_data changed to 0xFFFFFF at slot 5 -> transmitted bits still 0x421280.
REQ-033 reset=0 at slot 10 q1 -> the next edge shows scl_o=1, sda_oe=0, busy=0, done=0, and a following transfer is bit-exact.
REQ-034 Protocol monitor runs throughout all scenarios -> no SDA transition while scl_o=1 other than exactly one START and one STOP per transfer.

Source files
------------

// File: rtl/cam_sccb_master.sv
// SCCB write master: START, three 9-bit slots (8 data bits + ACK), STOP.
// Outputs are a registered decode of the present state, so pins lag the FSM by one clk.
module cam_sccb_master #(
  parameter int QTR_DIV = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] i2c_data,
  input  logic        enable,
  output logic        scl_o,
  output logic        sda_oe,
  input  logic        sda_i,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);
  // state | meaning
  // IDLE  | bus idle, waiting for enable
  // START | 2 quarters: SDA falls with SCL high, then SCL low
  // BIT   | 27 slots of 4 quarters; slots 8, 17, 26 sample ACK
  // STOP  | 3 quarters: SDA low, SCL high, then SDA released
  // DONE  | transfer finished, waits for enable low
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

  localparam int CW = $clog2(QTR_DIV);

  state_t      state;
  logic [CW-1:0] qcnt;
  logic [1:0]  phase;
  logic [4:0]  slot;
  logic [23:0] shreg;
  logic        qtick;
  logic        ack_slot;

  assign qtick    = (qcnt == CW'(QTR_DIV - 1));
  assign ack_slot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      qcnt    <= '0;
      phase   <= '0;
      slot    <= '0;
      shreg   <= '0;
      scl_o   <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      scl_o  <= 1'b1;
      sda_oe <= 1'b0;
      busy   <= 1'b1;
      done   <= 1'b0;
      qcnt   <= qtick ? '0 : qcnt + 1'b1;
      case (state)
        IDLE: begin
          busy  <= 1'b0;
          qcnt  <= '0;
          phase <= '0;
          slot  <= '0;
          if (enable) begin
            shreg   <= i2c_data;
            ack_err <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          scl_o  <= (phase == 2'd0);
          sda_oe <= 1'b1;
          if (qtick) begin
            if (phase == 2'd1) begin
              phase <= '0;
              slot  <= '0;
              state <= BIT;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        BIT: begin
          scl_o  <= (phase == 2'd1) || (phase == 2'd2);
          sda_oe <= ack_slot ? 1'b0 : ~shreg[23];
          if (qtick) begin
            phase <= phase + 1'b1;
            if (phase == 2'd2 && ack_slot)
              ack_err <= ack_err | sda_i;
            if (phase == 2'd3) begin
              if (!ack_slot)
                shreg <= {shreg[22:0], 1'b0};
              if (slot == 5'd26) begin
                phase <= '0;
                state <= STOP;
              end else begin
                slot <= slot + 1'b1;
              end
            end
          end
        end
        STOP: begin
          scl_o  <= (phase != 2'd0);
          sda_oe <= (phase != 2'd2);
          if (qtick) begin
            if (phase == 2'd2) begin
              phase <= '0;
              state <= DONE;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          qcnt <= '0;
          if (!enable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cam_sccb_master.sv
// Bench for cam_sccb_master: open-drain bus with a slave model, a bus monitor
// that records bits at each SCL rise, and a frame-level reference for checking.
module tb_cam_sccb_master;
  localparam int Q = 2;
  localparam int LAT = 1 + 113 * Q;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] i2c_data;
  logic        enable;
  logic        scl_o, sda_oe, sda_i, busy, done, ack_err;

  logic [2:0]  ack_mask;   // bit0: slot 8, bit1: slot 17, bit2: slot 26 acked by slave
  logic        slave_pull;
  logic        clr;
  logic        in_frame;
  int          starts, stops, glitches, rises, falls;
  logic        bits [0:31];
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;

  cam_sccb_master #(.QTR_DIV(Q)) dut (
    .clk(clk), .reset(reset), .i2c_data(i2c_data), .enable(enable),
    .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i),
    .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  assign slave_pull = in_frame && ((falls == 9 && ack_mask[0]) ||
                                   (falls == 18 && ack_mask[1]) ||
                                   (falls == 27 && ack_mask[2]));
  assign sda_i = ~(sda_oe | slave_pull);

  always @(negedge clk) begin
    if (clr) begin
      starts <= 0; stops <= 0; glitches <= 0; rises <= 0; falls <= 0;
      in_frame <= 1'b0;
    end else begin
      if (sda_i != prev_sda) begin
        if (prev_scl && scl_o) begin
          if (!sda_i) begin
            starts <= starts + 1; rises <= 0; falls <= 0; in_frame <= 1'b1;
          end else begin
            stops <= stops + 1; in_frame <= 1'b0;
          end
        end else if (prev_scl != scl_o) begin
          glitches <= glitches + 1;
        end
      end
      if (!prev_scl && scl_o) begin
        if (rises < 32) bits[rises] <= sda_i;
        rises <= rises + 1;
      end
      if (prev_scl && !scl_o) falls <= falls + 1;
    end
    prev_scl <= scl_o;
    prev_sda <= sda_i;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  // One write frame; expected stream is the three bytes MSB first, each followed by its ACK bit.
  task automatic run_transfer(input string tag, input logic [23:0] data, input logic [2:0] acks,
                              input bit hold_en, input bit disturb);
    int cyc;
    logic [26:0] got, exp;
    ack_mask = acks;
    clear_mon();
    i2c_data = data;
    enable   = 1'b1;
    @(posedge clk); #1;
    if (!hold_en) enable = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (disturb && cyc == 44) begin i2c_data = 24'hFFFFFF; enable = 1'b1; end
      if (disturb && cyc == 60) begin i2c_data = $urandom; enable = 1'b0; end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, LAT);
    for (int i = 0; i < 27; i++) got[26 - i] = bits[i];
    exp = {data[23:16], ~acks[0], data[15:8], ~acks[1], data[7:0], ~acks[2]};
    chk({tag, "_bits"}, got, exp);
    chk({tag, "_ack_err"}, ack_err, (acks != 3'b111));
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_frames"}, {starts[7:0], stops[7:0]}, 16'h0101);
    chk({tag, "_glitch"}, glitches, 0);
    if (!hold_en) begin
      @(posedge clk); #1;
      chk({tag, "_done_one_cycle"}, done, 1'b0);
    end
  endtask

  initial begin
    int cyc;
    reset = 1'b0; enable = 1'b0; i2c_data = 24'h0; ack_mask = 3'b111; clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", scl_o, 1'b1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    reset = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);

    run_transfer("basic", 24'h421280, 3'b111, 1'b0, 1'b0);
    run_transfer("nack17", 24'h421280, 3'b101, 1'b0, 1'b0);

    // enable held high through done: no restart until it drops
    run_transfer("hold", 24'h5A3C96, 3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_done", {busy, done}, 2'b01);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_release_done", done, 1'b0);
    chk("hold_release_scl", scl_o, 1'b1);
    run_transfer("hold_second", 24'hA5C3E1, 3'b111, 1'b0, 1'b0);

    run_transfer("disturb", 24'h421280, 3'b111, 1'b0, 1'b1);

    // reset during slot 10 while SCL is high
    ack_mask = 3'b111;
    clear_mon();
    i2c_data = 24'h421280; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    cyc = 0;
    while (!(rises == 11 && scl_o) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    chk("rst_mid_reached", (cyc < 2000), 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_outputs", {scl_o, sda_oe, busy, done, ack_err}, 5'b10000);
    @(negedge clk); reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rst_mid_idle", {scl_o, sda_oe, busy}, 3'b100);
    run_transfer("after_rst", 24'h421280, 3'b111, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_transfer("rand", 24'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
